// File: rtl/cover_toggle_collector.sv
// Toggle-coverage receiver: sticky first-hit bitmap, one-shot index stream over valid/ready,
// and a drain-then-clear sequence that restarts a collection epoch.
module cover_toggle_collector #(
  parameter int COVER_WIDTH = 5,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 8065,
  localparam int IDX_W = $clog2(COVER_TOTAL),
  localparam int CNT_W = $clog2(COVER_WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COVER_WIDTH-1:0] valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_index,
  input  logic                   clear_req,
  output logic                   clear_done,
  output logic [COVER_WIDTH-1:0] hit_map,
  output logic [CNT_W-1:0]       hit_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] BASE = IDX_W'(COVER_INDEX);

  function automatic logic [CNT_W-1:0] popcount(input logic [COVER_WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < COVER_WIDTH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic [COVER_WIDTH-1:0] hit_map_q, hit_map_d;
  logic [COVER_WIDTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]       hit_count_q, hit_count_d;
  logic                   clear_done_q, clear_done_d;

  logic [COVER_WIDTH-1:0] new_s;
  logic [COVER_WIDTH-1:0] pop_s;
  logic [COVER_WIDTH-1:0] low_onehot_s;
  logic [IDX_W-1:0]       low_idx_s;

  // Fixed-priority pick of the lowest pending bit (one-hot and its bit number).
  always_comb begin
    low_onehot_s = pending_q & (~pending_q + COVER_WIDTH'(1));
    low_idx_s    = '0;
    for (int i = COVER_WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        low_idx_s = IDX_W'(i);
      end else begin
        low_idx_s = low_idx_s;
      end
    end
  end

  assign out_valid  = |pending_q;
  assign out_index  = out_valid ? (BASE + low_idx_s) : '0;
  assign clear_done = clear_done_q;
  assign hit_map    = hit_map_q;
  assign hit_count  = hit_count_q;

  // Next-state: record new hits in RUN, retire the popped bit, sequence drain/clear.
  always_comb begin
    new_s        = (state_q == RUN) ? (valid & ~hit_map_q) : '0;
    pop_s        = (out_valid && out_ready) ? low_onehot_s : '0;
    pending_d    = (pending_q & ~pop_s) | new_s;
    hit_map_d    = hit_map_q | new_s;
    hit_count_d  = hit_count_q + popcount(new_s);
    state_d      = state_q;
    clear_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (clear_req) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // Pulse is registered on entry so it is high exactly during the CLEAR cycle.
        if (pending_q == '0) begin
          state_d      = CLEAR;
          clear_done_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      CLEAR: begin
        hit_map_d   = '0;
        hit_count_d = '0;
        state_d     = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= RUN;
      hit_map_q    <= '0;
      pending_q    <= '0;
      hit_count_q  <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_map_q    <= hit_map_d;
      pending_q    <= pending_d;
      hit_count_q  <= hit_count_d;
      clear_done_q <= clear_done_d;
    end
  end

endmodule
